// File: rtl/tensor_core_pkg.sv
// Shared types and width helpers for the token encoder slice.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package tensor_core_pkg;

    // Encoder control states.
    typedef enum logic [2:0] {
        TE_IDLE = 3'd0,
        TE_RD   = 3'd1,
        TE_CMP  = 3'd2,
        TE_NEXT = 3'd3,
        TE_EMIT = 3'd4,
        TE_DONE = 3'd5
    } token_encoder_state_e;

    // Default geometry of the encoder.
    localparam int TE_DATA_WIDTH_DEF    = 8;
    localparam int TE_IN_ADDR_WIDTH_DEF = 4;
    localparam int TE_NUM_ENTRIES_DEF   = 16;
    localparam int TE_MAX_TOK_LEN_DEF   = 4;
    localparam int TE_CODE_WIDTH_DEF    = 8;

    // The unknown-byte code defaults to every bit set, whatever the code width.
    localparam logic TE_UNK_FILL = 1'b1;

    // Entry-index width (EW).
    function automatic int te_ew(input int num_entries);
        return $clog2(num_entries);
    endfunction

    // Byte-offset-within-entry width (OW).
    function automatic int te_ow(input int max_tok_len);
        return $clog2(max_tok_len);
    endfunction

endpackage

// File: rtl/token_matcher.sv
// Per-entry byte comparator: owns the offset counter and classifies one byte pair.
// Latency: classification is combinational; offset updates on the next clock edge.
// Backpressure: none; the caller decides when to clear or advance the offset.
module token_matcher
    import tensor_core_pkg::*;
#(
    parameter int DATA_WIDTH  = TE_DATA_WIDTH_DEF,
    parameter int MAX_TOK_LEN = TE_MAX_TOK_LEN_DEF
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                off_clr_i,
    input  logic                                off_inc_i,
    input  logic                                first_entry_i,
    input  logic [DATA_WIDTH-1:0]               in_byte_i,
    input  logic [DATA_WIDTH-1:0]               voc_byte_i,
    output logic [te_ow(MAX_TOK_LEN)-1:0]       off_o,
    output logic                                match_o,
    output logic [te_ow(MAX_TOK_LEN):0]         len_o,
    output logic                                cont_o,
    output logic                                end_o
);

    localparam int OW = te_ow(MAX_TOK_LEN);

    logic [OW-1:0] off_q, off_d;
    logic          voc_zero;
    logic          bytes_eq;
    logic          off_zero;
    logic          off_last;

    // Offset counter next state: clear wins over advance.
    always_comb begin
        off_d = off_q;
        if (off_clr_i) begin
            off_d = '0;
        end else if (off_inc_i) begin
            off_d = off_q + OW'(1);
        end
    end

    // Offset counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q <= '0;
        end else begin
            off_q <= off_d;
        end
    end

    // Classify the current byte pair; a zero vocab byte terminates the entry.
    always_comb begin
        voc_zero = (voc_byte_i == '0);
        bytes_eq = (in_byte_i == voc_byte_i);
        off_zero = (off_q == '0);
        off_last = (off_q == OW'(MAX_TOK_LEN - 1));
        off_o    = off_q;
        end_o    = first_entry_i && off_zero && (in_byte_i == '0);
        match_o  = (voc_zero && !off_zero) || (bytes_eq && !voc_zero && off_last);
        cont_o   = bytes_eq && !voc_zero && !off_last;
        len_o    = voc_zero ? {1'b0, off_q} : (OW + 1)'(MAX_TOK_LEN);
    end

endmodule

// File: rtl/token_encoder.sv
// Tokenises a zero-terminated input string against a vocabulary SRAM, one code per token.
// Latency: 2 cycles per byte compare, 1 per skipped entry, code one cycle after the deciding step.
// Backpressure: code_valid/code_data hold stable until code_ready; no scanning while stalled.
// Build option: TOKEN_ENCODER_LONGEST_MATCH_EN selects longest-match instead of first-match.
module token_encoder
    import tensor_core_pkg::*;
#(
    parameter int DATA_WIDTH    = TE_DATA_WIDTH_DEF,
    parameter int IN_ADDR_WIDTH = TE_IN_ADDR_WIDTH_DEF,
    parameter int NUM_ENTRIES   = TE_NUM_ENTRIES_DEF,
    parameter int MAX_TOK_LEN   = TE_MAX_TOK_LEN_DEF,
    parameter int CODE_WIDTH    = TE_CODE_WIDTH_DEF,
    parameter logic [CODE_WIDTH-1:0] UNK_CODE = {CODE_WIDTH{TE_UNK_FILL}}
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               cs,
    output logic [IN_ADDR_WIDTH-1:0]                           in_addr,
    input  logic [DATA_WIDTH-1:0]                              in_data,
    output logic [te_ew(NUM_ENTRIES)+te_ow(MAX_TOK_LEN)-1:0]   voc_addr,
    input  logic [DATA_WIDTH-1:0]                              voc_data,
    output logic                                               code_valid,
    output logic [CODE_WIDTH-1:0]                              code_data,
    input  logic                                               code_ready,
    output logic                                               busy,
    output logic                                               done,
    output logic [IN_ADDR_WIDTH:0]                             code_count
);

    localparam int EW    = te_ew(NUM_ENTRIES);
    localparam int OW    = te_ow(MAX_TOK_LEN);
    localparam int AW    = IN_ADDR_WIDTH;
    localparam int DEPTH = 2 ** AW;

    token_encoder_state_e state_q, state_d;

    // pos is one bit wider than the input address so it can reach DEPTH without wrapping.
    logic [AW:0]   pos_q, pos_d;
    logic [EW-1:0] entry_q, entry_d;
    logic [OW:0]   best_len_q, best_len_d;
    logic [EW-1:0] best_idx_q, best_idx_d;
    logic          best_unk_q, best_unk_d;
    logic [AW:0]   count_q, count_d;

    logic          off_clr;
    logic          off_inc;
    logic [OW-1:0] off;
    logic          m_match;
    logic [OW:0]   m_len;
    logic          m_cont;
    logic          m_end;

    logic [AW+1:0]         rd_addr;
    logic                  past_end;
    logic [DATA_WIDTH-1:0] in_byte;
    logic [AW+1:0]         end_sum;
    logic                  pos_limit;

    // Read address, end-of-buffer masking and post-token position.
    always_comb begin
        rd_addr   = {1'b0, pos_q} + (AW + 2)'(off);
        past_end  = |rd_addr[AW+1:AW];
        in_byte   = past_end ? '0 : in_data;
        end_sum   = {1'b0, pos_q} + (AW + 2)'(best_len_q);
        pos_limit = (end_sum >= (AW + 2)'(DEPTH));
    end

    token_matcher #(
        .DATA_WIDTH  (DATA_WIDTH),
        .MAX_TOK_LEN (MAX_TOK_LEN)
    ) u_matcher (
        .clk           (clk),
        .rst_n         (rst_n),
        .off_clr_i     (off_clr),
        .off_inc_i     (off_inc),
        .first_entry_i (entry_q == '0),
        .in_byte_i     (in_byte),
        .voc_byte_i    (voc_data),
        .off_o         (off),
        .match_o       (m_match),
        .len_o         (m_len),
        .cont_o        (m_cont),
        .end_o         (m_end)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TE_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the datapath updates each transition implies.
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        entry_d    = entry_q;
        best_len_d = best_len_q;
        best_idx_d = best_idx_q;
        best_unk_d = best_unk_q;
        count_d    = count_q;
        off_clr    = 1'b0;
        off_inc    = 1'b0;
        case (state_q)
            TE_IDLE, TE_DONE: begin
                if (cs) begin
                    pos_d      = '0;
                    entry_d    = '0;
                    best_len_d = '0;
                    best_idx_d = '0;
                    best_unk_d = 1'b0;
                    count_d    = '0;
                    off_clr    = 1'b1;
                    state_d    = TE_RD;
                end
            end
            TE_RD: begin
                state_d = TE_CMP;
            end
            TE_CMP: begin
                if (m_end) begin
                    state_d = TE_DONE;
                end else if (m_match) begin
`ifdef TOKEN_ENCODER_LONGEST_MATCH_EN
                    // Strictly longer only, so ties keep the lowest entry index.
                    if (m_len > best_len_q) begin
                        best_idx_d = entry_q;
                        best_len_d = m_len;
                    end
                    state_d = TE_NEXT;
`else
                    best_idx_d = entry_q;
                    best_len_d = m_len;
                    state_d    = TE_EMIT;
`endif
                end else if (m_cont) begin
                    off_inc = 1'b1;
                    state_d = TE_RD;
                end else begin
                    state_d = TE_NEXT;
                end
            end
            TE_NEXT: begin
                off_clr = 1'b1;
                entry_d = entry_q + EW'(1);
                if (entry_q == EW'(NUM_ENTRIES - 1)) begin
                    // Nothing matched: consume a single byte as unknown.
                    if (best_len_q == '0) begin
                        best_unk_d = 1'b1;
                        best_len_d = (OW + 1)'(1);
                    end
                    state_d = TE_EMIT;
                end else begin
                    state_d = TE_RD;
                end
            end
            TE_EMIT: begin
                if (code_ready) begin
                    pos_d      = end_sum[AW:0];
                    count_d    = count_q + (AW + 1)'(1);
                    entry_d    = '0;
                    best_len_d = '0;
                    best_idx_d = '0;
                    best_unk_d = 1'b0;
                    off_clr    = 1'b1;
                    state_d    = pos_limit ? TE_DONE : TE_RD;
                end
            end
            default: begin
                state_d = TE_IDLE;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q      <= '0;
            entry_q    <= '0;
            best_len_q <= '0;
            best_idx_q <= '0;
            best_unk_q <= 1'b0;
            count_q    <= '0;
        end else begin
            pos_q      <= pos_d;
            entry_q    <= entry_d;
            best_len_q <= best_len_d;
            best_idx_q <= best_idx_d;
            best_unk_q <= best_unk_d;
            count_q    <= count_d;
        end
    end

    // Outputs decoded from registered state; code_data is zero when not valid.
    always_comb begin
        in_addr    = rd_addr[AW-1:0];
        voc_addr   = {entry_q, off};
        code_valid = (state_q == TE_EMIT);
        code_data  = '0;
        if (state_q == TE_EMIT) begin
            code_data = best_unk_q ? UNK_CODE : CODE_WIDTH'(best_idx_q);
        end
        busy       = (state_q == TE_RD) || (state_q == TE_CMP) ||
                     (state_q == TE_NEXT) || (state_q == TE_EMIT);
        done       = (state_q == TE_DONE);
        code_count = count_q;
    end

endmodule

// File: tb/tb_token_encoder.sv
// Directed bench for token_encoder with SRAM models and an expected-code scoreboard.
// Latency: n/a.
// Backpressure: code_ready driven by the bench, including a held-low stall.
module tb_token_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs;
    logic [3:0] in_addr;
    logic [7:0] in_data;
    logic [5:0] voc_addr;
    logic [7:0] voc_data;
    logic       code_valid;
    logic [7:0] code_data;
    logic       code_ready;
    logic       busy;
    logic       done;
    logic [4:0] code_count;

    logic [7:0] in_mem  [16];
    logic [7:0] voc_mem [64];

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q [$];
    logic       stalled = 1'b0;
    logic [7:0] held = '0;

`ifdef TOKEN_ENCODER_LONGEST_MATCH_EN
    localparam logic [4:0] ABCAB_CNT = 5'd2;
`else
    localparam logic [4:0] ABCAB_CNT = 5'd3;
`endif

    always #5 clk = ~clk;

    token_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs         (cs),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .voc_addr   (voc_addr),
        .voc_data   (voc_data),
        .code_valid (code_valid),
        .code_data  (code_data),
        .code_ready (code_ready),
        .busy       (busy),
        .done       (done),
        .code_count (code_count)
    );

    // Synchronous SRAMs with one cycle of read latency.
    always @(posedge clk) begin
        in_data  <= in_mem[in_addr];
        voc_data <= voc_mem[voc_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor, sampled at the falling edge: stall stability and scoreboard pop.
    task automatic mon();
        logic [7:0] e;
        if (code_valid && !code_ready) begin
            if (stalled) chk("stall_code_stable", code_data, held);
            held    = code_data;
            stalled = 1'b1;
        end else begin
            stalled = 1'b0;
        end
        if (code_valid && code_ready) begin
            chk("code_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("code_value", code_data, e);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        cs = 1'b1;
        step();
        cs = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        chk(tag, done, 1);
    endtask

    task automatic clear_voc();
        for (int i = 0; i < 64; i++) voc_mem[i] = 8'h00;
    endtask

    task automatic set_entry(input int e, input string s);
        for (int k = 0; k < 4; k++) voc_mem[e*4+k] = (k < s.len()) ? s[k] : 8'h00;
    endtask

    task automatic load_in(input string s);
        for (int i = 0; i < 16; i++) in_mem[i] = (i < s.len()) ? s[i] : 8'h00;
    endtask

    task automatic setup_abc();
        clear_voc();
        set_entry(0, "ab");
        set_entry(1, "a");
        set_entry(2, "abc");
        load_in("abcab");
    endtask

    task automatic push_abcab();
`ifdef TOKEN_ENCODER_LONGEST_MATCH_EN
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h00);
`else
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
`endif
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_in_addr"},    in_addr,    0);
        chk({pfx, "_voc_addr"},   voc_addr,   0);
        chk({pfx, "_code_valid"}, code_valid, 0);
        chk({pfx, "_code_data"},  code_data,  0);
        chk({pfx, "_busy"},       busy,       0);
        chk({pfx, "_done"},       done,       0);
        chk({pfx, "_code_count"}, code_count, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        cs         = 1'b0;
        code_ready = 1'b1;
        clear_voc();
        load_in("");
        repeat (3) step();
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        step();

        // Mixed vocabulary: known tokens and an unknown byte.
        setup_abc();
        push_abcab();
        start();
        chk("abc_busy_after_cs", busy, 1);
        wait_done("abc_done", 3000);
        chk("abc_count", code_count, ABCAB_CNT);
        chk("abc_queue_empty", exp_q.size(), 0);
        chk("abc_busy_low", busy, 0);

        // Empty input ends the run straight from the first compare.
        load_in("");
        start();
        chk("null_done_cleared", done, 0);
        step();
        step();
        chk("null_done_3cyc", done, 1);
        chk("null_busy_low", busy, 0);
        chk("null_count", code_count, 0);

        // Downstream stall during the first code.
        setup_abc();
        push_abcab();
        code_ready = 1'b0;
        start();
        begin
            int n;
            n = 0;
            while (!code_valid && n < 200) begin
                step();
                n++;
            end
        end
        chk("bp_valid_seen", code_valid, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_valid_held", code_valid, 1);
        end
        code_ready = 1'b1;
        wait_done("bp_done", 3000);
        chk("bp_count", code_count, ABCAB_CNT);
        chk("bp_queue_empty", exp_q.size(), 0);

        // Full buffer with no terminator: position must stop exactly at the end.
        clear_voc();
        set_entry(0, "a");
        load_in("aaaaaaaaaaaaaaaa");
        repeat (16) exp_q.push_back(8'h00);
        start();
        wait_done("fill_done", 6000);
        chk("fill_count", code_count, 16);
        chk("fill_queue_empty", exp_q.size(), 0);

        // Lookahead past the end must read as zero, not the wrapped first byte.
        clear_voc();
        set_entry(0, "ab");
        set_entry(1, "a");
        set_entry(2, "b");
        load_in("baaaaaaaaaaaaaaa");
        exp_q.push_back(8'h02);
        repeat (15) exp_q.push_back(8'h01);
        start();
        wait_done("wrap_done", 6000);
        chk("wrap_count", code_count, 16);
        chk("wrap_queue_empty", exp_q.size(), 0);

        // Entry filling all MAX_TOK_LEN bytes, then a shorter one.
        clear_voc();
        set_entry(0, "abcd");
        set_entry(1, "ab");
        load_in("abcdab");
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        start();
        wait_done("max_done", 3000);
        chk("max_count", code_count, 2);
        chk("max_queue_empty", exp_q.size(), 0);

        // Reset during the first compare aborts; a restart repeats the full result.
        setup_abc();
        start();
        step();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        step();
        step();
        chk("midrst_no_code", code_valid, 0);
        rst_n = 1'b1;
        step();
        push_abcab();
        start();
        wait_done("midrst_done", 3000);
        chk("midrst_count", code_count, ABCAB_CNT);
        chk("midrst_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
